// File: rtl/intersection_pkg.sv
// Shared phase encoding and direction constants for the intersection scheduler.
package intersection_pkg;

  typedef enum logic [2:0] {
    PhArToNs = 3'd0,
    PhNsG    = 3'd1,
    PhNsY    = 3'd2,
    PhArToEw = 3'd3,
    PhEwG    = 3'd4,
    PhEwY    = 3'd5,
    PhWalk   = 3'd6
  } phase_e;

  localparam logic DirNs = 1'b0;
  localparam logic DirEw = 1'b1;

endpackage

// File: rtl/intersection_phase_scheduler_if.sv
// Detector/button inputs, lamp outputs and status of the intersection scheduler.
interface intersection_phase_scheduler_if;
  logic       tick;
  logic       ns_car;
  logic       ew_car;
  logic       ped_req;
  logic       ns_red;
  logic       ns_yellow;
  logic       ns_green;
  logic       ew_red;
  logic       ew_yellow;
  logic       ew_green;
  logic       walk;
  logic       ped_ack;
  logic [2:0] phase;

  modport master (
    output tick, ns_car, ew_car, ped_req,
    input  ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green, walk, ped_ack, phase
  );

  modport slave (
    input  tick, ns_car, ew_car, ped_req,
    output ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green, walk, ped_ack, phase
  );
endinterface

// File: rtl/phase_timer.sv
// Loadable down-counter advancing on tick; expired when a tick lands on zero.
module phase_timer #(
  parameter int unsigned    TW      = 8,
  parameter logic [TW-1:0]  RST_VAL = '0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic [TW-1:0] load_val,
  input  logic          tick,
  output logic          expired
);

  logic [TW-1:0] cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= RST_VAL;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (tick && (cnt_q != '0)) begin
      cnt_q <= cnt_q - TW'(1);
    end
  end

  assign expired = tick && (cnt_q == '0);

endmodule

// File: rtl/intersection_phase_scheduler.sv
// Two-road traffic phase FSM with green rest on no cross demand and pedestrian WALK insertion.
module intersection_phase_scheduler
  import intersection_pkg::*;
#(
  parameter int unsigned GREEN_TICKS  = 8,
  parameter int unsigned YELLOW_TICKS = 3,
  parameter int unsigned ALLRED_TICKS = 2,
  parameter int unsigned WALK_TICKS   = 6,
  parameter int unsigned TW           = 8
) (
  input logic                          clk,
  input logic                          reset,
  intersection_phase_scheduler_if.slave bus
);

  phase_e        state_q, state_d;
  logic          ped_pending_q, ped_pending_d;
  logic          next_dir_q, next_dir_d;
  logic          ped_ack_q, ped_ack_d;
  logic          load, expired;
  logic [TW-1:0] load_val;

  function automatic logic [TW-1:0] dur_m1(phase_e p);
    case (p)
      PhNsG, PhEwG: dur_m1 = TW'(GREEN_TICKS - 1);
      PhNsY, PhEwY: dur_m1 = TW'(YELLOW_TICKS - 1);
      PhWalk:       dur_m1 = TW'(WALK_TICKS - 1);
      default:      dur_m1 = TW'(ALLRED_TICKS - 1);
    endcase
  endfunction

  phase_timer #(
    .TW      (TW),
    .RST_VAL (TW'(ALLRED_TICKS - 1))
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .load_val (load_val),
    .tick     (bus.tick),
    .expired  (expired)
  );

  always_comb begin
    state_d       = state_q;
    next_dir_d    = next_dir_q;
    ped_pending_d = ped_pending_q | bus.ped_req;
    ped_ack_d     = 1'b0;
    case (state_q)
      PhArToNs: if (expired) begin
        if (ped_pending_q) begin
          state_d       = PhWalk;
          next_dir_d    = DirNs;
          ped_ack_d     = 1'b1;
          // A request in the serving cycle must survive the clear.
          ped_pending_d = bus.ped_req;
        end else begin
          state_d = PhNsG;
        end
      end
      PhNsG: if (expired && (bus.ew_car || ped_pending_q)) state_d = PhNsY;
      PhNsY: if (expired) state_d = PhArToEw;
      PhArToEw: if (expired) begin
        if (ped_pending_q) begin
          state_d       = PhWalk;
          next_dir_d    = DirEw;
          ped_ack_d     = 1'b1;
          ped_pending_d = bus.ped_req;
        end else begin
          state_d = PhEwG;
        end
      end
      PhEwG: if (expired && (bus.ns_car || ped_pending_q)) state_d = PhEwY;
      PhEwY: if (expired) state_d = PhArToNs;
      PhWalk: if (expired) state_d = (next_dir_q == DirNs) ? PhNsG : PhEwG;
      default: state_d = PhArToNs;
    endcase
    // Resting in green keeps the timer at zero since no reload happens.
    load     = (state_d != state_q);
    load_val = dur_m1(state_d);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= PhArToNs;
      ped_pending_q <= 1'b0;
      next_dir_q    <= DirNs;
      ped_ack_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      ped_pending_q <= ped_pending_d;
      next_dir_q    <= next_dir_d;
      ped_ack_q     <= ped_ack_d;
    end
  end

  always_comb begin
    bus.ns_red    = 1'b1;
    bus.ns_yellow = 1'b0;
    bus.ns_green  = 1'b0;
    bus.ew_red    = 1'b1;
    bus.ew_yellow = 1'b0;
    bus.ew_green  = 1'b0;
    case (state_q)
      PhNsG: begin bus.ns_red = 1'b0; bus.ns_green  = 1'b1; end
      PhNsY: begin bus.ns_red = 1'b0; bus.ns_yellow = 1'b1; end
      PhEwG: begin bus.ew_red = 1'b0; bus.ew_green  = 1'b1; end
      PhEwY: begin bus.ew_red = 1'b0; bus.ew_yellow = 1'b1; end
      default: ;
    endcase
  end

  assign bus.walk    = (state_q == PhWalk);
  assign bus.ped_ack = ped_ack_q;
  assign bus.phase   = state_q;

endmodule

// File: doc/intersection_phase_scheduler.md
# intersection_phase_scheduler

Sequences a two-road (north-south / east-west) intersection through timed green, yellow and all-red phases. It holds green on a road while the cross road has no demand, and inserts a pedestrian WALK phase on request. All durations are counted in `tick` pulses from the system time base, so the block can run on `clk` while phase timing is set in seconds-scale units. It drives the lamp outputs for both roads plus the pedestrian signal.

## Interface
- `GREEN_TICKS`, default 8: minimum green duration per road, in ticks (≥1)
- `YELLOW_TICKS`, default 3: yellow duration, in ticks (≥1)
- `ALLRED_TICKS`, default 2: all-red clearance duration, in ticks (≥1)
- `WALK_TICKS`, default 6: pedestrian WALK duration, in ticks (≥1)
- `TW`, default 8: timer width; every duration must be ≤ 2^TW
- `clk` in 1: clock
- `reset` in 1: reset, asynchronous, active-high
- `tick` in 1: time-base enable; timing advances only on cycles where `tick`=1
- `ns_car` in 1: level; vehicle waiting on the NS road
- `ew_car` in 1: level; vehicle waiting on the EW road
- `ped_req` in 1: single-cycle pulse; pedestrian button
- `ns_red`, `ns_yellow`, `ns_green` out 1 each: NS lamps, exactly one high at all times
- `ew_red`, `ew_yellow`, `ew_green` out 1 each: EW lamps, exactly one high at all times
- `walk` out 1: pedestrian WALK lamp
- `ped_ack` out 1: one-cycle pulse when a pending request is served
- `phase` out 3: current state encoding, for debug and status

## Operation
- States: `AR_TO_NS`, `NS_G`, `NS_Y`, `AR_TO_EW`, `EW_G`, `EW_Y`, `WALK`.
- Main cycle: `NS_G` → `NS_Y` → `AR_TO_EW` → `EW_G` → `EW_Y` → `AR_TO_NS` → `NS_G`.
- Durations: `NS_G`/`EW_G` = GREEN_TICKS; `*_Y` = YELLOW_TICKS; `AR_*` = ALLRED_TICKS; `WALK` = WALK_TICKS.
- Timer:
  - On state entry the timer loads (duration−1).
  - Each `tick` with timer≠0 decrements it.
  - Expiry is `tick`=1 and timer=0. A state therefore lasts exactly N ticks.
- Green rest: at expiry in `NS_G`, leave only if `ew_car`=1 or `ped_pending`=1. Otherwise stay, with the timer held at 0, and re-evaluate every tick. `EW_G` behaves the same way using `ns_car`.
- Pedestrian handling:
  - `ped_req` sets `ped_pending`.
  - At expiry of either `AR_*` state with `ped_pending`=1, enter `WALK` and pulse `ped_ack` in the entry cycle. `ped_pending` clears on that same edge.
  - Register `next_dir` records the green the all-red state was heading to. `WALK` expiry goes to that green.
- Simultaneous events: if `ped_req` arrives in the same cycle that `ped_pending` clears, `ped_pending` stays set and is served on the next all-red. Requests during `WALK` are latched the same way.
- Lamp decode (Moore, from registered state only):
  - `AR_*` and `WALK`: both roads red.
  - `NS_G`/`NS_Y`: NS green/yellow, EW red. `EW_*` is symmetric.
  - `walk`=1 only in `WALK`.
- Illegal state encodings: go to `AR_TO_NS` on the next clock, regardless of `tick`.
- Reset values:
  - state=`AR_TO_NS`, timer=ALLRED_TICKS−1, `ped_pending`=0, `next_dir`=NS.
  - Outputs: `ns_red`=`ew_red`=1, all other lamps 0, `walk`=0, `ped_ack`=0, `phase`=`AR_TO_NS`.

## Timing
- A state change takes effect on the clock edge of the expiry cycle. Lamps and `phase` change in the following cycle; there is no further output latency.
- `ped_ack` is high for exactly one clk cycle, coincident with the first cycle of `walk`=1.
- `ped_req` is sampled every clk, independent of `tick`.
- `ns_car`/`ew_car` are sampled only in the green expiry cycle.
- Reset asserted mid-phase forces the reset state immediately, dropping any pending request. After release, the first transition occurs after ALLRED_TICKS ticks.
- Never two greens, never a green without a preceding all-red: every path passes through an `AR_*` state.

## Structure
- Package `intersection_pkg`: 3-bit phase encoding constants/typedef, NS/EW direction constant.
- Sub-module `phase_timer`: TW-bit loadable down-counter. Inputs `load`, `load_val`, `tick`; output `expired`.
- Top level holds the FSM, `ped_pending`, `next_dir` and the lamp decode.

## Test plan
Parameters for all scenarios: GREEN=4, YELLOW=2, ALLRED=1, WALK=3, `tick`=1 every cycle unless stated.
- Reset release with `ew_car`=`ns_car`=1 held: phase sequence AR(1), NS_G(4), NS_Y(2), AR(1), EW_G(4), EW_Y(2), AR(1), repeating. Exactly one lamp per road at every cycle.
- `ew_car`=0, no pedestrian request: NS_G holds indefinitely. Raise `ew_car` at cycle 20 → NS_Y starts on the next cycle.
- `ped_req` pulse during NS_G → NS_Y, AR_TO_EW, WALK(3 cycles, `ped_ack` in its first cycle), then EW_G. Both roads red throughout WALK.
- `ped_req` pulse in the `ped_ack` cycle → a second WALK occurs after EW_Y/AR_TO_NS.
- `tick` every 4th cycle: NS_G lasts 16 clk cycles. `ped_req` between ticks is still captured.
- Reset asserted mid-EW_G with `ped_pending`=1 → outputs immediately both-red, `walk`=0. After release there is no WALK and NS_G follows after 1 tick.
